// File: rtl/boneless_pkg.sv
// Shared opcode decode constants, error codes and branch-condition helper
// for the Boneless retirement monitor.
package boneless_pkg;

  localparam logic [4:0] OPCODE_CMP      = 5'b00001;
  localparam logic [4:0] OPCODE_ALU_LAST = 5'b00011;
  localparam logic [4:0] OPCODE_LD       = 5'b00100;
  localparam logic [4:0] OPCODE_ST       = 5'b00101;
  localparam logic [4:0] OPCODE_LDX      = 5'b00110;
  localparam logic [4:0] OPCODE_STX      = 5'b00111;
  localparam logic [4:0] OPCODE_ADDI     = 5'b01011;
  localparam logic [4:0] OPCODE_JAL      = 5'b01110;
  localparam logic [4:0] OPCODE_JR       = 5'b01111;

  localparam logic       OPCLASS_C       = 1'b1;

  localparam logic [2:0] COND_F_FALSE    = 3'b000;
  localparam logic [2:0] COND_F_Z        = 3'b001;
  localparam logic [2:0] COND_F_S        = 3'b010;
  localparam logic [2:0] COND_F_C        = 3'b011;
  localparam logic [2:0] COND_F_V        = 3'b100;
  localparam logic [2:0] COND_F_ULE      = 3'b101;
  localparam logic [2:0] COND_F_SLT      = 3'b110;
  localparam logic [2:0] COND_F_SLE      = 3'b111;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_PC      = 3'd1,
    ERR_WDT     = 3'd2,
    ERR_EXT_OP  = 3'd3,
    ERR_EXT_DUP = 3'd4,
    ERR_FLAGS   = 3'd5,
    ERR_WEN     = 3'd6
  } err_code_e;

  // cond_bits is insn[14:11]: condition select plus the expected polarity bit.
  function automatic logic boneless_cond_taken(input logic [3:0] cond_bits,
                                               input logic [3:0] flags);
    logic v, c, s, z, cond;
    {v, c, s, z} = flags;
    cond = 1'b0;
    case (cond_bits[3:1])
      COND_F_Z:   cond = z;
      COND_F_S:   cond = s;
      COND_F_C:   cond = c;
      COND_F_V:   cond = v;
      COND_F_ULE: cond = !c | z;
      COND_F_SLT: cond = s ^ v;
      COND_F_SLE: cond = (s ^ v) | z;
      default:    cond = 1'b0;
    endcase
    return cond_bits[0] == cond;
  endfunction

endpackage

// File: rtl/boneless_pc_history.sv
// Ring buffer of recently retired PCs; index 0 reads the newest entry.
module boneless_pc_history #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_pc,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]             rd_pc,
  output logic                          valid
);

  localparam int unsigned IDX_W = $clog2(HIST_DEPTH);

  logic [DATA_W-1:0] mem [HIST_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W:0]    fill;
  logic [IDX_W-1:0]  rd_addr;

  // fill saturates at HIST_DEPTH so valid stays meaningful after wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_pc;
      wr_ptr      <= wr_ptr + IDX_W'(1);
      if (fill != (IDX_W+1)'(HIST_DEPTH))
        fill <= fill + (IDX_W+1)'(1);
    end
  end

  assign rd_addr = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_pc   = mem[rd_addr];
  assign valid   = {1'b0, rd_idx} < fill;

endmodule

// File: rtl/boneless_retire_monitor.sv
// Run-time checker on the Boneless retirement port: control flow, cycle budget,
// ext-bus rules, flag preservation and write-enable legality, with sticky error.
module boneless_retire_monitor
  import boneless_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned MAX_CYCLES = 8,
  parameter int unsigned RET_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fi_stb,
  input  logic [DATA_W-1:0]             fi_pc,
  input  logic [15:0]                   fi_insn,
  input  logic [3:0]                    fi_flags,
  input  logic                          fi_mem_w_en,
  input  logic                          fi_ext_r_en,
  input  logic                          fi_ext_w_en,
  output logic                          err,
  output logic [2:0]                    err_code,
  output logic [DATA_W-1:0]             err_pc,
  output logic [RET_W-1:0]              retired,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [DATA_W-1:0]             hist_rd_pc,
  output logic                          hist_valid
);

  localparam int unsigned WDT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] pred_pc, pred_pc_nx, last_pc;
  logic              pred_valid, pred_valid_nx;
  logic [3:0]        prev_flags;
  logic              pend_r, pend_w;
  logic [WDT_W-1:0]  wdt_cnt, wdt_cnt_nx;
  err_code_e         err_sel;

  logic [4:0]        opcode;
  logic [DATA_W-1:0] pc_inc, imm8, imm11;
  logic              ext_rd, ext_wr, flag_setting, is_cmp;
  logic              bad_pc, bad_wdt, bad_ext_op, bad_ext_dup, bad_flags, bad_wen;

  assign opcode       = fi_insn[15:11];
  assign pc_inc       = fi_pc + DATA_W'(1);
  assign imm8         = {{(DATA_W-8){fi_insn[7]}}, fi_insn[7:0]};
  assign imm11        = {{(DATA_W-11){fi_insn[10]}}, fi_insn[10:0]};
  assign ext_rd       = fi_ext_r_en | pend_r;
  assign ext_wr       = fi_ext_w_en | pend_w;
  assign flag_setting = (opcode <= OPCODE_ALU_LAST) || (opcode == OPCODE_ADDI);
  assign is_cmp       = (opcode == OPCODE_CMP) && (fi_insn[1:0] == 2'b10);

  // Individual violation detectors; JR clears pred_valid so the next PC is unchecked.
  assign bad_pc      = fi_stb && (state == ST_RUN) && pred_valid && (fi_pc != pred_pc);
  assign bad_wdt     = !fi_stb && (wdt_cnt == WDT_W'(MAX_CYCLES - 1));
  assign bad_ext_op  = fi_stb && ((ext_rd && (opcode != OPCODE_LDX)) ||
                                  (ext_wr && (opcode != OPCODE_STX)) ||
                                  ((opcode == OPCODE_LDX) && !ext_rd) ||
                                  ((opcode == OPCODE_STX) && !ext_wr));
  assign bad_ext_dup = (fi_ext_r_en && fi_ext_w_en) ||
                       ((fi_ext_r_en || fi_ext_w_en) && (pend_r || pend_w));
  assign bad_flags   = fi_stb && (state != ST_IDLE) && !flag_setting && (fi_flags != prev_flags);
  assign bad_wen     = fi_stb && fi_mem_w_en &&
                       (is_cmp || (opcode == OPCODE_STX) || (opcode == OPCODE_JR) ||
                        (fi_insn[15] == OPCLASS_C));

  always_comb begin
    state_nx      = state;
    err_sel       = ERR_NONE;
    pred_pc_nx    = pred_pc;
    pred_valid_nx = pred_valid;
    wdt_cnt_nx    = wdt_cnt;

    if (bad_pc)           err_sel = ERR_PC;
    else if (bad_wdt)     err_sel = ERR_WDT;
    else if (bad_ext_op)  err_sel = ERR_EXT_OP;
    else if (bad_ext_dup) err_sel = ERR_EXT_DUP;
    else if (bad_flags)   err_sel = ERR_FLAGS;
    else if (bad_wen)     err_sel = ERR_WEN;

    if (fi_stb) begin
      pred_valid_nx = 1'b1;
      if (opcode == OPCODE_JAL)
        pred_pc_nx = pc_inc + imm8;
      else if (opcode == OPCODE_JR)
        pred_valid_nx = 1'b0;
      else if ((fi_insn[15] == OPCLASS_C) && boneless_cond_taken(fi_insn[14:11], fi_flags))
        pred_pc_nx = pc_inc + imm11;
      else
        pred_pc_nx = pc_inc;
    end

    if (fi_stb)
      wdt_cnt_nx = '0;
    else if (wdt_cnt != WDT_W'(MAX_CYCLES))
      wdt_cnt_nx = wdt_cnt + WDT_W'(1);

    case (state)
      ST_IDLE: begin
        if (err_sel != ERR_NONE) state_nx = ST_HALT;
        else if (fi_stb)         state_nx = ST_RUN;
      end
      ST_RUN:  if (err_sel != ERR_NONE) state_nx = ST_HALT;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err        <= 1'b0;
      err_code   <= '0;
      err_pc     <= '0;
      retired    <= '0;
      pred_pc    <= '0;
      pred_valid <= 1'b0;
      prev_flags <= '0;
      last_pc    <= '0;
      pend_r     <= 1'b0;
      pend_w     <= 1'b0;
      wdt_cnt    <= '0;
    end else begin
      if ((state != ST_HALT) && (err_sel != ERR_NONE)) begin
        err      <= 1'b1;
        err_code <= 3'(err_sel);
        err_pc   <= fi_stb ? fi_pc : last_pc;
      end
      if (fi_stb) begin
        retired    <= retired + RET_W'(1);
        prev_flags <= fi_flags;
        last_pc    <= fi_pc;
      end
      pred_pc    <= pred_pc_nx;
      pred_valid <= pred_valid_nx;
      wdt_cnt    <= wdt_cnt_nx;
      pend_r     <= fi_stb ? 1'b0 : (pend_r | fi_ext_r_en);
      pend_w     <= fi_stb ? 1'b0 : (pend_w | fi_ext_w_en);
    end
  end

  boneless_pc_history #(
    .DATA_W    (DATA_W),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fi_stb),
    .wr_pc (fi_pc),
    .rd_idx(hist_rd_idx),
    .rd_pc (hist_rd_pc),
    .valid (hist_valid)
  );

endmodule

// File: tb/tb_boneless_retire_monitor.sv
// Scoreboard bench for boneless_retire_monitor: expected outputs are queued
// when each cycle is driven and compared once the DUT has registered them.
module tb_boneless_retire_monitor;

  localparam logic [15:0] I_MOVL = 16'h4000;
  localparam logic [15:0] I_JAL  = 16'h70FE;
  localparam logic [15:0] I_BEQ  = 16'h9805;
  localparam logic [15:0] I_BSV  = 16'hE7FF;
  localparam logic [15:0] I_LD   = 16'h2000;
  localparam logic [15:0] I_ST   = 16'h2800;
  localparam logic [15:0] I_LDX  = 16'h3000;
  localparam logic [15:0] I_STX  = 16'h3800;
  localparam logic [15:0] I_JR   = 16'h7800;
  localparam logic [15:0] I_CMP  = 16'h0802;

  typedef struct {
    int          due;
    logic        err;
    logic [2:0]  code;
    logic [15:0] pc;
    logic [31:0] ret;
  } sb_t;

  logic        clk, rst, fi_stb, fi_mem_w_en, fi_ext_r_en, fi_ext_w_en;
  logic [15:0] fi_pc, fi_insn;
  logic [3:0]  fi_flags;
  logic        err, hist_valid;
  logic [2:0]  err_code, hist_rd_idx;
  logic [15:0] err_pc, hist_rd_pc;
  logic [31:0] retired;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  sb_t         sb_q[$];
  sb_t         mon_e;

  logic        m_err;
  logic [2:0]  m_code;
  logic [15:0] m_pc, m_last_pc;
  logic [31:0] m_ret;
  logic [3:0]  m_flags;
  logic [15:0] m_hist[$];

  boneless_retire_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .fi_stb     (fi_stb),
    .fi_pc      (fi_pc),
    .fi_insn    (fi_insn),
    .fi_flags   (fi_flags),
    .fi_mem_w_en(fi_mem_w_en),
    .fi_ext_r_en(fi_ext_r_en),
    .fi_ext_w_en(fi_ext_w_en),
    .err        (err),
    .err_code   (err_code),
    .err_pc     (err_pc),
    .retired    (retired),
    .hist_rd_idx(hist_rd_idx),
    .hist_rd_pc (hist_rd_pc),
    .hist_valid (hist_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare registered outputs one edge after the cycle that produced them.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      check_eq("err",      32'(err),      32'(mon_e.err));
      check_eq("err_code", 32'(err_code), 32'(mon_e.code));
      check_eq("err_pc",   32'(err_pc),   32'(mon_e.pc));
      check_eq("retired",  retired,       mon_e.ret);
    end
  end

  task automatic push_exp();
    sb_t e;
    e.due = cyc + 1; e.err = m_err; e.code = m_code; e.pc = m_pc; e.ret = m_ret;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; code is the violation this cycle should raise (0 = none).
  task automatic drive(input logic stb, input logic [15:0] pc, input logic [15:0] insn,
                       input logic [3:0] flags, input logic wen, input logic r,
                       input logic w, input logic [2:0] code);
    @(negedge clk);
    fi_stb = stb; fi_pc = pc; fi_insn = insn; fi_flags = flags;
    fi_mem_w_en = wen; fi_ext_r_en = r; fi_ext_w_en = w;
    if (!m_err && code != 3'd0) begin
      m_err = 1'b1; m_code = code; m_pc = pc;
    end
    if (stb) begin
      m_ret++; m_last_pc = pc; m_flags = flags; m_hist.push_front(pc);
    end
    push_exp();
  endtask

  task automatic idle(input logic r, input logic w, input logic [2:0] code);
    drive(1'b0, m_last_pc, 16'h0000, m_flags, 1'b0, r, w, code);
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] insn, input logic [3:0] flags,
                        input logic wen, input logic r, input logic w, input logic [2:0] code);
    drive(1'b1, pc, insn, flags, wen, r, w, code);
    idle(1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      rst = 1'b0; fi_stb = 1'b0; fi_mem_w_en = 1'b0; fi_ext_r_en = 1'b0; fi_ext_w_en = 1'b0;
      m_err = 1'b0; m_code = 3'd0; m_pc = 16'h0; m_last_pc = 16'h0; m_ret = 32'd0;
      m_flags = 4'h0; m_hist.delete();
      push_exp();
    end
    @(negedge clk);
    rst = 1'b1;
    push_exp();
  endtask

  task automatic check_hist(input int idx);
    hist_rd_idx = 3'(idx);
    #1;
    check_eq("hist_rd_pc", 32'(hist_rd_pc), (idx < m_hist.size()) ? 32'(m_hist[idx]) : 32'h0);
    check_eq("hist_valid", 32'(hist_valid), (idx < m_hist.size()) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b0; fi_stb = 1'b0; fi_pc = '0; fi_insn = '0; fi_flags = '0;
    fi_mem_w_en = 1'b0; fi_ext_r_en = 1'b0; fi_ext_w_en = 1'b0; hist_rd_idx = '0;

    // Reset state and sequential retirements with history readback.
    do_reset();
    check_hist(0);
    for (int i = 0; i < 3; i++) retire(16'(i), I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check_hist(0);
    check_hist(2);
    check_hist(3);
    for (int i = 3; i < 10; i++) retire(16'(i), I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check_hist(0);
    check_hist(7);

    // JAL backward by two, then a wrong target.
    do_reset();
    retire(16'h0010, I_JAL,  4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h000F, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0010, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    do_reset();
    retire(16'h0010, I_JAL,  4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0011, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1);
    retire(16'h0055, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Conditional branches: taken forward, taken by -1, and not taken.
    do_reset();
    retire(16'h00FF, I_MOVL, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0100, I_BEQ,  4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0106, I_MOVL, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0107, I_BSV,  4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0107, I_MOVL, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0108, I_MOVL, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
    do_reset();
    retire(16'h00FF, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0100, I_BEQ,  4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0106, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1);

    // Watchdog: eighth idle cycle after a retirement fires; reset clears it.
    do_reset();
    retire(16'h0020, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (6) idle(1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b0, 3'd2);
    repeat (2) idle(1'b0, 1'b0, 3'd0);
    do_reset();
    check_hist(0);

    // External bus rules.
    do_reset();
    retire(16'h0030, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b1, 3'd0);
    retire(16'h0031, I_LD,   4'h0, 1'b0, 1'b0, 1'b0, 3'd3);
    do_reset();
    retire(16'h0040, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(1'b1, 1'b0, 3'd0);
    idle(1'b1, 1'b0, 3'd4);
    do_reset();
    retire(16'h0050, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(1'b1, 1'b0, 3'd0);
    retire(16'h0051, I_LDX,  4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0052, I_STX,  4'h0, 1'b0, 1'b0, 1'b1, 3'd0);
    retire(16'h0053, I_LDX,  4'h0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Flag preservation and write-enable legality, including priority.
    do_reset();
    retire(16'h0060, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0061, I_ST,   4'h1, 1'b0, 1'b0, 1'b0, 3'd5);
    do_reset();
    retire(16'h0070, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0071, I_CMP,  4'h1, 1'b1, 1'b0, 1'b0, 3'd6);
    do_reset();
    retire(16'h0080, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0081, I_JR,   4'h1, 1'b1, 1'b0, 1'b0, 3'd5);
    do_reset();
    retire(16'h0090, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0091, I_JR,   4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0500, I_MOVL, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0501, I_CMP,  4'h2, 1'b0, 1'b0, 1'b0, 3'd0);
    retire(16'h0502, I_MOVL, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0);

    repeat (2) @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/boneless_retire_monitor.md
Name: boneless_retire_monitor

Overview:
Synthesizable run-time checker for the Boneless core's instruction-retirement port (fi_*). It tracks each retirement and checks control flow, the per-instruction cycle budget, the external-bus access rules, flag preservation and write-enable legality. On the first violation it latches a sticky error with a code and the offending PC. It also keeps a ring buffer of recently retired PCs for debug readout.

Parameters:
DATA_W, 16, data/PC width; all PC arithmetic is modulo 2^DATA_W
HIST_DEPTH, 8, retired-PC history entries; power of two, >=2
MAX_CYCLES, 8, maximum clk cycles allowed between consecutive fi_stb pulses
RET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
fi_stb  in  1  one-cycle strobe: instruction retires this cycle
fi_pc  in  DATA_W  PC of the retiring instruction
fi_insn  in  16  retiring instruction word
fi_flags  in  4  {V,C,S,Z} after the retiring instruction
fi_mem_w_en  in  1  retiring instruction writes the register file/memory
fi_ext_r_en  in  1  ext read strobe; may occur on the fi_stb cycle or one cycle earlier
fi_ext_w_en  in  1  ext write strobe; same timing as fi_ext_r_en
err  out  1  sticky violation flag
err_code  out  3  first violation code (0 = none)
err_pc  out  DATA_W  fi_pc at the first violation (0 if a watchdog fires before any retirement)
retired  out  RET_W  retirement count; wraps to 0
hist_rd_idx  in  $clog2(HIST_DEPTH)  0 = most recent retirement
hist_rd_pc  out  DATA_W  combinational history read; 0 for entries not yet written
hist_valid  out  1  hist_rd_idx < number of retirements since reset

Behaviour:
- Reset (rst=0 sampled at clk): every output is 0, the FSM enters IDLE, history is cleared, and the watchdog and pending-ext state are cleared. A reset mid-error also clears err.
- FSM states:
  - IDLE: no PC prediction held. The first fi_stb skips the PC and flag checks, runs all other checks, then moves to RUN.
  - RUN: all checks are active on every fi_stb.
  - HALT: entered on the first violation. err=1; err_code and err_pc are frozen. History and retired keep updating. HALT is left only by reset.
- PC prediction, computed on each fi_stb for the next retirement:
  - JAL (insn[15:11]=01110): target = pc+1+sext(imm8).
  - Class C (insn[15]=1), taken: target = pc+1+sext(imm11).
  - Class C, not taken: pc+1.
  - JR (01111): no prediction; the next PC check is skipped.
  - Anything else: pc+1.
- Branch taken condition: taken = (insn[11] == cond), with cond selected by insn[14:12] and evaluated on the fi_flags presented with the branch itself:
  - 000: 0
  - 001: Z
  - 010: S
  - 011: C
  - 100: V
  - 101: !C|Z
  - 110: S^V
  - 111: (S^V)|Z
- Error codes; when several fire on the same cycle, the lowest code wins:
  - 1 PC mismatch: fi_pc != predicted PC.
  - 2 watchdog: the cycle counter reaches MAX_CYCLES with no fi_stb. The counter increments every cycle, resets to 0 on fi_stb, saturates, and runs in IDLE as well.
  - 3 ext access (current-cycle or pending) retires with an opcode other than LDX (00110) for reads, or STX (00111) for writes.
  - 4 second ext strobe while one is already pending, or r_en and w_en asserted together.
  - 5 flags changed: fi_flags differs from the flags of the previous retirement on a non-flag-setting opcode (everything except opcodes 00000-00011 and 01011).
  - 6 fi_mem_w_en=1 on CMP (00001 with insn[1:0]=10), STX, JR or class C.
- Pending ext: an ext strobe without fi_stb sets pending_r or pending_w. Both pending bits clear on the next fi_stb. An LDX or STX retiring with neither a current nor a pending strobe of its kind is code 3.
- History: on each fi_stb, write fi_pc at wr_ptr and advance wr_ptr mod HIST_DEPTH. The read address is wr_ptr-1-hist_rd_idx.
- Latency: err, err_code and err_pc are registered and valid the cycle after the violating fi_stb (or watchdog cycle). retired increments on the same edge.

Decomposition:
- Package boneless_pkg holds:
  - opcode localparams (OPCODE_*, OPCLASS_*, COND_F_*);
  - err_code enum (ERR_NONE, ERR_PC, ERR_WDT, ERR_EXT_OP, ERR_EXT_DUP, ERR_FLAGS, ERR_WEN);
  - function boneless_cond_taken(insn, flags).
- Sub-module boneless_pc_history: the ring buffer, with ports clk, rst, wr_en, wr_pc, rd_idx, rd_pc, valid.

Test Plan:
- Reset, then retire pc 0x0000, 0x0001, 0x0002 (MOVL) with constant flags, one stb every 2 cycles -> err=0, retired=3; hist_rd_idx=0 gives 0x0002, hist_rd_idx=2 gives 0x0000.
- JAL at 0x0010 with imm8=0xFE, next retire at 0x000F -> no error. Instead retire at 0x0011 -> err_code=1, err_pc=0x0011.
- BEQ-style branch (cond=001, flag=1) with Z=1 and imm11=0x005 at 0x0100 -> next must be 0x0106. With Z=0 -> 0x0101; retiring at 0x0106 instead gives err_code=1.
- Hold fi_stb low for MAX_CYCLES=8 cycles after a retirement -> err=1, err_code=2 on cycle 9. Pulse rst low -> all outputs 0.
- fi_ext_w_en one cycle before the stb of an LD (00100) -> err_code=3. A second fi_ext_r_en while a read is pending -> err_code=4.
- ST (00101) retiring with fi_flags 0x1 after a previous 0x0 -> err_code=5. CMP retiring with fi_mem_w_en=1 -> err_code=6. Both on the same stb -> err_code=5.
